// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: arbitrates exceptions, mret and level IRQs, redirects/flushes the pipeline
// and sequences mepc/mcause/mtval/mstatus updates through one CSR write port. Optional: TRAP_VECTORED_EN.
module trap_ctrl #(
    parameter int XLEN    = 32,
    parameter int NUM_IRQ = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                exc_valid,
    input  logic [3:0]          exc_code,
    input  logic [XLEN-1:0]     exc_pc,
    input  logic [XLEN-1:0]     exc_tval,
    input  logic                mret,
    input  logic [XLEN-1:0]     next_pc,
    input  logic [NUM_IRQ-1:0]  irq_in,
    input  logic [NUM_IRQ-1:0]  mie,
    input  logic [XLEN-1:0]     mstatus,
    input  logic [XLEN-1:0]     mtvec,
    input  logic [XLEN-1:0]     mepc,
    output logic                csr_we,
    output logic [11:0]         csr_waddr,
    output logic [XLEN-1:0]     csr_wdata,
    output logic                redirect_valid,
    output logic [XLEN-1:0]     redirect_pc,
    output logic                flush,
    output logic                regwrite_cancel,
    output logic [NUM_IRQ-1:0]  irq_ack,
    output logic                busy
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_EPC   = 3'd1,
        W_CAUSE = 3'd2,
        W_TVAL  = 3'd3,
        W_STAT  = 3'd4,
        M_STAT  = 3'd5
    } state_t;

    // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
    function automatic logic [XLEN-1:0] trap_stat(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r        = s;
        r[7]     = s[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // Trap return: MIE <- MPIE, MPIE <- 1, MPP <- U.
    function automatic logic [XLEN-1:0] mret_stat(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r        = s;
        r[3]     = s[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b00;
        return r;
    endfunction

    state_t              state_r, state_s;
    logic [XLEN-1:0]     epc_r, epc_s, cause_r, cause_s, tval_r, tval_s, stat_r, stat_s;
    logic                we_s, rv_s, flush_s, cancel_s, busy_s;
    logic [11:0]         waddr_s;
    logic [XLEN-1:0]     wdata_s, rpc_s, base_s, irq_pc_s, irq_cause_s;
    logic [NUM_IRQ-1:0]  pend_s, ack_s;
    logic [4:0]          irq_idx_s;
    logic                irq_hit_s;

`ifndef TRAP_VECTORED_EN
    logic                mtvec_mode_unused_s;
    assign mtvec_mode_unused_s = ^mtvec[1:0];
`endif

    // Interrupt selection and redirect target computation.
    always_comb begin
        pend_s    = irq_in & mie;
        irq_hit_s = mstatus[3] && (pend_s != '0);
        irq_idx_s = 5'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend_s[i]) begin
                irq_idx_s = 5'(i);
            end else begin
                irq_idx_s = irq_idx_s;
            end
        end
        irq_cause_s = {1'b1, (XLEN-1)'(irq_idx_s) + (XLEN-1)'(16)};
        base_s      = {mtvec[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
        if (mtvec[1:0] == 2'b01) begin
            irq_pc_s = base_s + {irq_cause_s[XLEN-3:0], 2'b00};
        end else begin
            irq_pc_s = base_s;
        end
`else
        irq_pc_s = base_s;
`endif
    end

    // Next state, captured trap context and next registered outputs.
    always_comb begin
        state_s  = state_r;
        epc_s    = epc_r;
        cause_s  = cause_r;
        tval_s   = tval_r;
        stat_s   = stat_r;
        we_s     = 1'b0;
        waddr_s  = 12'h000;
        wdata_s  = '0;
        rv_s     = 1'b0;
        rpc_s    = '0;
        flush_s  = 1'b0;
        cancel_s = 1'b0;
        ack_s    = '0;
        busy_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (exc_valid) begin
                    state_s  = W_EPC;
                    epc_s    = exc_pc;
                    cause_s  = {{(XLEN-4){1'b0}}, exc_code};
                    tval_s   = exc_tval;
                    stat_s   = trap_stat(mstatus);
                    we_s     = 1'b1;
                    waddr_s  = ADDR_MEPC;
                    wdata_s  = exc_pc;
                    rv_s     = 1'b1;
                    rpc_s    = base_s;
                    flush_s  = 1'b1;
                    cancel_s = 1'b1;
                    busy_s   = 1'b1;
                end else if (mret) begin
                    state_s  = M_STAT;
                    we_s     = 1'b1;
                    waddr_s  = ADDR_MSTATUS;
                    wdata_s  = mret_stat(mstatus);
                    rv_s     = 1'b1;
                    rpc_s    = mepc;
                    flush_s  = 1'b1;
                    cancel_s = 1'b1;
                    busy_s   = 1'b1;
                end else if (irq_hit_s) begin
                    state_s  = W_EPC;
                    epc_s    = next_pc;
                    cause_s  = irq_cause_s;
                    tval_s   = '0;
                    stat_s   = trap_stat(mstatus);
                    we_s     = 1'b1;
                    waddr_s  = ADDR_MEPC;
                    wdata_s  = next_pc;
                    rv_s     = 1'b1;
                    rpc_s    = irq_pc_s;
                    flush_s  = 1'b1;
                    cancel_s = 1'b1;
                    ack_s    = (NUM_IRQ)'(1) << irq_idx_s;
                    busy_s   = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            W_EPC: begin
                state_s = W_CAUSE;
                we_s    = 1'b1;
                waddr_s = ADDR_MCAUSE;
                wdata_s = cause_r;
                busy_s  = 1'b1;
            end
            W_CAUSE: begin
                state_s = W_TVAL;
                we_s    = 1'b1;
                waddr_s = ADDR_MTVAL;
                wdata_s = tval_r;
                busy_s  = 1'b1;
            end
            W_TVAL: begin
                state_s = W_STAT;
                we_s    = 1'b1;
                waddr_s = ADDR_MSTATUS;
                wdata_s = stat_r;
                busy_s  = 1'b1;
            end
            W_STAT:  state_s = IDLE;
            M_STAT:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, trap context and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            epc_r           <= '0;
            cause_r         <= '0;
            tval_r          <= '0;
            stat_r          <= '0;
            csr_we          <= 1'b0;
            csr_waddr       <= 12'h000;
            csr_wdata       <= '0;
            redirect_valid  <= 1'b0;
            redirect_pc     <= '0;
            flush           <= 1'b0;
            regwrite_cancel <= 1'b0;
            irq_ack         <= '0;
            busy            <= 1'b0;
        end else begin
            state_r         <= state_s;
            epc_r           <= epc_s;
            cause_r         <= cause_s;
            tval_r          <= tval_s;
            stat_r          <= stat_s;
            csr_we          <= we_s;
            csr_waddr       <= waddr_s;
            csr_wdata       <= wdata_s;
            redirect_valid  <= rv_s;
            redirect_pc     <= rpc_s;
            flush           <= flush_s;
            regwrite_cancel <= cancel_s;
            irq_ack         <= ack_s;
            busy            <= busy_s;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl: exception, interrupt, collision, mret, reset abort, vectoring.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exc_valid;
    logic [3:0]  exc_code;
    logic [31:0] exc_pc, exc_tval, next_pc, mstatus, mtvec, mepc;
    logic        mret;
    logic [3:0]  irq_in, mie;
    logic        csr_we, redirect_valid, flush, regwrite_cancel, busy;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata, redirect_pc;
    logic [3:0]  irq_ack;

    int n_chk  = 0;
    int n_fail = 0;

    trap_ctrl #(.XLEN(32), .NUM_IRQ(4)) dut (
        .clk(clk), .rst_n(rst_n), .exc_valid(exc_valid), .exc_code(exc_code),
        .exc_pc(exc_pc), .exc_tval(exc_tval), .mret(mret), .next_pc(next_pc),
        .irq_in(irq_in), .mie(mie), .mstatus(mstatus), .mtvec(mtvec), .mepc(mepc),
        .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .regwrite_cancel(regwrite_cancel), .irq_ack(irq_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Checks the cycle-N+1 pulse outputs plus the CSR write of that cycle.
    task automatic chk_write(input string tag, input logic [11:0] addr, input logic [31:0] data);
        chk({tag, ".we"}, {31'd0, csr_we}, 32'd1);
        chk({tag, ".addr"}, {20'd0, csr_waddr}, {20'd0, addr});
        chk({tag, ".data"}, csr_wdata, data);
        chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".we"}, {31'd0, csr_we}, 32'd0);
        chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
        chk({tag, ".rv"}, {31'd0, redirect_valid}, 32'd0);
        chk({tag, ".ack"}, {28'd0, irq_ack}, 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_idle(tag);
        chk({tag, ".addr"}, {20'd0, csr_waddr}, 32'd0);
        chk({tag, ".data"}, csr_wdata, 32'd0);
        chk({tag, ".rpc"}, redirect_pc, 32'd0);
        chk({tag, ".flush"}, {31'd0, flush}, 32'd0);
        chk({tag, ".cancel"}, {31'd0, regwrite_cancel}, 32'd0);
    endtask

    initial begin
        logic [31:0] vec_exp;
        rst_n = 1'b0; exc_valid = 1'b0; exc_code = 4'd0; exc_pc = 32'd0; exc_tval = 32'd0;
        mret = 1'b0; next_pc = 32'd0; irq_in = 4'd0; mie = 4'd0;
        mstatus = 32'd0; mtvec = 32'd0; mepc = 32'd0;
        tick; tick;
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick;
        chk_idle("post_reset");

        // Illegal instruction trap
        mstatus = 32'h8; mtvec = 32'h200;
        exc_valid = 1'b1; exc_code = 4'd2; exc_pc = 32'h100; exc_tval = 32'hDEADBEEF;
        tick;
        chk("exc.rv", {31'd0, redirect_valid}, 32'd1);
        chk("exc.rpc", redirect_pc, 32'h200);
        chk("exc.flush", {31'd0, flush}, 32'd1);
        chk("exc.cancel", {31'd0, regwrite_cancel}, 32'd1);
        chk("exc.ack", {28'd0, irq_ack}, 32'd0);
        chk_write("exc.epc", 12'h341, 32'h100);
        exc_valid = 1'b0; mstatus = 32'h0;
        tick;
        chk("exc.rv2", {31'd0, redirect_valid}, 32'd0);
        chk("exc.flush2", {31'd0, flush}, 32'd0);
        chk_write("exc.cause", 12'h342, 32'h2);
        tick;
        chk_write("exc.tval", 12'h343, 32'hDEADBEEF);
        tick;
        chk_write("exc.stat", 12'h300, 32'h1880);
        tick;
        chk_idle("exc.done");

        // Interrupt: sources 1 and 2 pending, lowest wins; exception during busy ignored
        mstatus = 32'h8; irq_in = 4'b0110; mie = 4'b1111; next_pc = 32'h44;
        tick;
        chk("irq.ack", {28'd0, irq_ack}, 32'b0010);
        chk("irq.rv", {31'd0, redirect_valid}, 32'd1);
        chk("irq.rpc", redirect_pc, 32'h200);
        chk_write("irq.epc", 12'h341, 32'h44);
        irq_in = 4'b0000; exc_valid = 1'b1; exc_code = 4'd7; exc_pc = 32'h999;
        tick;
        chk("irq.ack2", {28'd0, irq_ack}, 32'd0);
        chk_write("irq.cause", 12'h342, 32'h80000011);
        exc_valid = 1'b0;
        tick;
        chk_write("irq.tval", 12'h343, 32'h0);
        tick;
        chk_write("irq.stat", 12'h300, 32'h1880);
        tick;
        chk_idle("irq.done");

        // Exception and interrupt together: exception wins, irq stays blocked after MIE cleared
        mstatus = 32'h8; irq_in = 4'b0001; mie = 4'b0001;
        exc_valid = 1'b1; exc_code = 4'd5; exc_pc = 32'h300; exc_tval = 32'h1234;
        tick;
        chk("col.ack", {28'd0, irq_ack}, 32'd0);
        chk_write("col.epc", 12'h341, 32'h300);
        exc_valid = 1'b0; mstatus = 32'h1880;
        tick;
        chk_write("col.cause", 12'h342, 32'h5);
        tick;
        chk_write("col.tval", 12'h343, 32'h1234);
        tick;
        chk_write("col.stat", 12'h300, 32'h1880);
        tick;
        chk_idle("col.done");
        tick;
        chk_idle("col.blocked");
        irq_in = 4'b0000;

        // mret
        mstatus = 32'h1880; mepc = 32'h48; mret = 1'b1;
        tick;
        chk("mret.rv", {31'd0, redirect_valid}, 32'd1);
        chk("mret.rpc", redirect_pc, 32'h48);
        chk("mret.flush", {31'd0, flush}, 32'd1);
        chk_write("mret.stat", 12'h300, 32'h88);
        mret = 1'b0;
        tick;
        chk_idle("mret.done");

        // Vectored interrupt from source 0, then reset during W_CAUSE
`ifdef TRAP_VECTORED_EN
        vec_exp = 32'h240;
`else
        vec_exp = 32'h200;
`endif
        mstatus = 32'h8; mtvec = 32'h201; irq_in = 4'b0001; mie = 4'b0001; next_pc = 32'h80;
        tick;
        chk("vec.rpc", redirect_pc, vec_exp);
        chk("vec.ack", {28'd0, irq_ack}, 32'b0001);
        chk_write("vec.epc", 12'h341, 32'h80);
        irq_in = 4'b0000;
        tick;
        chk_write("vec.cause", 12'h342, 32'h80000010);
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk_idle("abort.after");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
